char_link_rx: RTL and testbench
===============================

CHAR_LINK_RX -- requirements
Module: char_link_rx

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, is the number of output FIFO entries (power of two, at least 2).
REQ-002 Parameter CWIDTH, default 7, is the character/symbol width.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 rx_sym  input  CWIDTH  link symbol, sampled every posedge clk.
REQ-006 out_char  output  CWIDTH  character at FIFO head.
REQ-007 out_last  output  1  head character is the final character of its frame.
REQ-008 out_valid  output  1  FIFO non-empty; out_char/out_last are valid.
REQ-009 out_ready  input  1  consumer accepts head; a pop occurs on a posedge where out_valid && out_ready.
REQ-010 overflow  output  1  sticky flag: a character was dropped because the FIFO was full.
REQ-011 frame_err  output  1  sticky flag: a protocol violation was detected.
REQ-012 clr_err  input  1  clears overflow and frame_err on posedge.
REQ-013 frame_cnt  output  16  count of completed frames; wraps 16'hFFFF -> 0.
REQ-014 fifo_level  output  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.

Function
REQ-015 Link protocol: SYM_IDLE = 7'h7F; SYM_START = 7'h00; data symbols are 7'h01..7'h7E; a frame is START, then zero or more data symbols, then IDLE.
REQ-016 The state machine SHALL use states HUNT, IDLE and FRAME.
REQ-017 HUNT: SYM_IDLE -> IDLE; any other symbol -> stay in HUNT, with no error and no push.
REQ-018 IDLE: SYM_START -> FRAME; SYM_IDLE -> stay; data symbol -> set frame_err, go to HUNT.
REQ-019 FRAME, data symbol: if the stage register is full, push it with last=0; then load the symbol into the stage register.
REQ-020 FRAME, SYM_IDLE: if the stage register is full, push it with last=1; increment frame_cnt; go to IDLE.
REQ-021 An empty frame (START immediately followed by IDLE) increments frame_cnt and pushes nothing.
REQ-022 FRAME, SYM_START: if the stage register is full, push it with last=1; set frame_err; do not increment frame_cnt; stay in FRAME and start a new frame.
REQ-023 Push timing: a character sampled at edge N is written to the FIFO at edge N+1 (the edge that samples the next symbol).
REQ-024 The FIFO is first-word-fall-through: out_valid rises directly after the write edge when the FIFO was empty.
REQ-025 Push when full without a simultaneous pop: drop the character, set overflow, leave FIFO contents and level unchanged.
REQ-026 Push and pop on the same edge while full: both occur, the level stays FIFO_DEPTH, and overflow is not set.
REQ-027 Push and pop on the same edge while empty: the push is accepted and the pop is ignored, because out_valid was low.
REQ-028 FIFO pointers wrap modulo FIFO_DEPTH.
REQ-029 fifo_level SHALL equal the number of pushes minus the number of pops at all times.
REQ-030 clr_err on the same edge as an error event: the event wins and the flag reads 1 after that edge.

Reset
REQ-031 Asynchronous reset SHALL force: state=HUNT, stage register empty, FIFO empty, out_valid=0, out_char=0, out_last=0, overflow=0, frame_err=0, frame_cnt=0, fifo_level=0.
REQ-032 Reset mid-frame discards the staged character and all FIFO contents.
REQ-033 After reset, no frame is recognised until a SYM_IDLE is sampled; a transmitter that drives 7'h00 out of its own reset is therefore not mistaken for a START.

Structure
REQ-034 SYM_IDLE, SYM_START and enum rx_state_t {HUNT, IDLE, FRAME} SHALL live in the shared package InstructionStruct.
REQ-035 The FIFO SHALL be a separate sub-module char_fifo: synchronous, FWFT, entry width CWIDTH+1 ({last, char}), depth FIFO_DEPTH, with full/empty/level outputs.
REQ-036 char_link_rx SHALL contain only the protocol FSM, the stage register, the counters and the sticky flags.

Verification
REQ-037 Reset, then 7F,00,48,69,7F, out_ready=1 -> output 'H'(last=0) then 'i'(last=1); frame_cnt=1; no flags set.
REQ-038 Apply 00,00,7F,00,41,7F straight out of reset -> only 'A'(last=1) is delivered; frame_cnt=1; frame_err=0.
REQ-039 out_ready=0, a single frame of 20 chars 0x41..0x54 -> first 16 stored, then overflow=1 and fifo_level=16; draining yields 0x41..0x50.
REQ-040 Full FIFO with out_ready=1 while a frame continues streaming -> no drop, overflow stays 0, level stays 16.
REQ-041 IDLE then 41 -> frame_err=1, nothing pushed; 7F,00,7F -> frame_cnt+1; clr_err -> frame_err=0.
REQ-042 Mid-frame 00,41,42,00,43,7F -> 'A'(0), 'B'(1), 'C'(1), frame_err=1, frame_cnt=1; assert reset after the first 'B' is staged -> FIFO empty, state HUNT.

Source files
------------

// File: rtl/char_link_rx_pkg.sv
// Shared link-protocol definitions: reserved symbols and receiver FSM states.
package InstructionStruct;

    localparam logic [6:0] SYM_IDLE  = 7'h7F;
    localparam logic [6:0] SYM_START = 7'h00;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        IDLE  = 2'd1,
        FRAME = 2'd2
    } rx_state_t;

endpackage

// File: rtl/char_link_rx_fifo.sv
// First-word-fall-through character FIFO; each entry holds {last, char}.
module char_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;

    logic w_empty;
    logic w_full;
    logic w_rd;
    logic w_wr;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == (AW+1)'(DEPTH));
    assign w_rd    = i_rd_en && !w_empty;
    // A write into a full FIFO is still accepted when the head leaves on the same edge.
    assign w_wr    = i_wr_en && (!w_full || w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= r_level + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

    assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_level   = r_level;

endmodule

// File: rtl/char_link_rx.sv
// Character link receiver: frames START/data/IDLE symbols into {last, char} FIFO entries.
module char_link_rx
    import InstructionStruct::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CWIDTH     = 7
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CWIDTH-1:0]             rx_sym,
    output logic [CWIDTH-1:0]             out_char,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    output logic                          frame_err,
    input  logic                          clr_err,
    output logic [15:0]                   frame_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    rx_state_t          r_state;
    rx_state_t          w_state_next;
    logic               r_stage_valid;
    logic [CWIDTH-1:0]  r_stage_char;
    logic               r_overflow;
    logic               r_frame_err;
    logic [15:0]        r_frame_cnt;

    logic               w_is_idle;
    logic               w_is_start;
    logic               w_is_data;
    logic               w_push;
    logic               w_push_last;
    logic               w_frame_done;
    logic               w_proto_err;
    logic               w_ovf_set;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [CWIDTH:0]    w_fifo_rd_data;

    assign w_is_idle  = (rx_sym == CWIDTH'(SYM_IDLE));
    assign w_is_start = (rx_sym == CWIDTH'(SYM_START));
    assign w_is_data  = !w_is_idle && !w_is_start;

    // Every symbol seen in FRAME flushes the staged character; only a data symbol marks it non-final.
    assign w_push       = (r_state == FRAME) && r_stage_valid;
    assign w_push_last  = !w_is_data;
    assign w_frame_done = (r_state == FRAME) && w_is_idle;
    assign w_proto_err  = ((r_state == IDLE) && w_is_data) ||
                          ((r_state == FRAME) && w_is_start);
    // When full, a pop is only possible if out_ready is high, which frees a slot for the push.
    assign w_ovf_set    = w_push && w_fifo_full && !out_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            HUNT: begin
                if (w_is_idle) begin
                    w_state_next = IDLE;
                end
            end
            IDLE: begin
                if (w_is_start) begin
                    w_state_next = FRAME;
                end else if (w_is_data) begin
                    w_state_next = HUNT;
                end
            end
            FRAME: begin
                if (w_is_idle) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= HUNT;
            r_stage_valid <= 1'b0;
            r_stage_char  <= '0;
            r_overflow    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_state <= w_state_next;

            if ((r_state == FRAME) && w_is_data) begin
                r_stage_valid <= 1'b1;
                r_stage_char  <= rx_sym;
            end else begin
                r_stage_valid <= 1'b0;
            end

            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end

            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end

            if (w_proto_err) begin
                r_frame_err <= 1'b1;
            end else if (clr_err) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CWIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_push),
        .i_wr_data ({w_push_last, r_stage_char}),
        .i_rd_en   (out_ready),
        .o_rd_data (w_fifo_rd_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_level   (fifo_level)
    );

    assign out_char  = w_fifo_rd_data[CWIDTH-1:0];
    assign out_last  = w_fifo_rd_data[CWIDTH];
    assign out_valid = !w_fifo_empty;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_char_link_rx.sv
// Bench for char_link_rx: frame-level reference model compared every cycle plus directed literal checks.
module tb_char_link_rx;

    logic        clk;
    logic        reset;
    logic [6:0]  rx_sym;
    logic [6:0]  out_char;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic        frame_err;
    logic        clr_err;
    logic [15:0] frame_cnt;
    logic [4:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    char_link_rx #(.FIFO_DEPTH(16), .CWIDTH(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_sym     (rx_sym),
        .out_char   (out_char),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .clr_err    (clr_err),
        .frame_cnt  (frame_cnt),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: link is either unsynchronised, between frames, or inside a frame
    // holding at most one pending character whose "last" bit depends on the following symbol.
    bit          m_sync;
    bit          m_inframe;
    bit          m_has;
    logic [6:0]  m_pend;
    logic [7:0]  m_q[$];
    bit          m_ovf;
    bit          m_ferr;
    logic [15:0] m_cnt;
    bit          t_pop, t_push, t_ovf_ev, t_ferr_ev;
    logic [7:0]  t_item;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_sync = 0; m_inframe = 0; m_has = 0; m_pend = '0;
            m_q.delete();
            m_ovf = 0; m_ferr = 0; m_cnt = '0;
        end else begin
            t_pop = out_ready && (m_q.size() > 0);
            t_push = 0; t_ovf_ev = 0; t_ferr_ev = 0; t_item = '0;
            if (!m_sync) begin
                if (rx_sym == 7'h7F) m_sync = 1;
            end else if (!m_inframe) begin
                if (rx_sym == 7'h00) m_inframe = 1;
                else if (rx_sym != 7'h7F) begin
                    t_ferr_ev = 1;
                    m_sync = 0;
                end
            end else begin
                if (m_has) begin
                    t_push = 1;
                    t_item = {(rx_sym == 7'h7F || rx_sym == 7'h00), m_pend};
                end
                if (rx_sym == 7'h7F) begin
                    m_has = 0; m_inframe = 0; m_cnt = m_cnt + 16'd1;
                end else if (rx_sym == 7'h00) begin
                    m_has = 0; t_ferr_ev = 1;
                end else begin
                    m_has = 1; m_pend = rx_sym;
                end
            end
            if (t_pop) void'(m_q.pop_front());
            if (t_push) begin
                if (m_q.size() < 16) m_q.push_back(t_item);
                else t_ovf_ev = 1;
            end
            if (t_ovf_ev) m_ovf = 1; else if (clr_err) m_ovf = 0;
            if (t_ferr_ev) m_ferr = 1; else if (clr_err) m_ferr = 0;
        end
    end

    always @(negedge clk) begin
        check("out_valid", int'(out_valid), int'(m_q.size() > 0));
        check("out_char", int'(out_char), (m_q.size() > 0) ? int'(m_q[0][6:0]) : 0);
        check("out_last", int'(out_last), (m_q.size() > 0) ? int'(m_q[0][7]) : 0);
        check("fifo_level", int'(fifo_level), m_q.size());
        check("overflow", int'(overflow), int'(m_ovf));
        check("frame_err", int'(frame_err), int'(m_ferr));
        check("frame_cnt", int'(frame_cnt), int'(m_cnt));
    end

    // Log of characters the consumer accepted, as {last, char}.
    logic [7:0] got[$];
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) got.push_back({out_last, out_char});
    end

    task automatic tick(input logic [6:0] s);
        rx_sym = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_sym = 7'h00;
        clr_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        got.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rx_sym = 7'h00; out_ready = 1'b0; clr_err = 1'b0;
        @(negedge clk);
        check("rst_valid", int'(out_valid), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_cnt", int'(frame_cnt), 0);
        check("rst_char", int'(out_char), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic two-character frame
        out_ready = 1'b1;
        tick(7'h7F); tick(7'h00); tick(7'h48); tick(7'h69); tick(7'h7F);
        repeat (3) tick(7'h7F);
        check("hi_count", got.size(), 2);
        if (got.size() == 2) begin
            check("hi_H", int'(got[0]), 8'h48);
            check("hi_i", int'(got[1]), 8'hE9);
        end
        check("hi_cnt", int'(frame_cnt), 1);
        check("hi_flags", int'({overflow, frame_err}), 0);

        // START symbols out of reset are ignored until IDLE
        do_reset();
        out_ready = 1'b1;
        tick(7'h00); tick(7'h00); tick(7'h7F); tick(7'h00); tick(7'h41); tick(7'h7F);
        repeat (3) tick(7'h7F);
        check("hunt_count", got.size(), 1);
        if (got.size() == 1) check("hunt_A", int'(got[0]), 8'hC1);
        check("hunt_cnt", int'(frame_cnt), 1);
        check("hunt_ferr", int'(frame_err), 0);

        // Overflow, then full-with-pop streaming, then drain
        do_reset();
        out_ready = 1'b0;
        tick(7'h7F); tick(7'h00);
        for (int i = 0; i < 20; i++) tick(7'(8'h41 + i));
        check("ovf_level", int'(fifo_level), 16);
        check("ovf_flag", int'(overflow), 1);
        clr_err = 1'b1;
        tick(7'h55);
        check("ovf_event_wins", int'(overflow), 1);
        out_ready = 1'b1;
        tick(7'h56);
        clr_err = 1'b0;
        check("full_pop_clr", int'(overflow), 0);
        check("full_pop_level", int'(fifo_level), 16);
        for (int i = 0; i < 4; i++) tick(7'(8'h57 + i));
        check("stream_level", int'(fifo_level), 16);
        check("stream_ovf", int'(overflow), 0);
        tick(7'h7F);
        for (int i = 0; i < 40 && out_valid; i++) tick(7'h7F);
        check("drain_empty", int'(out_valid), 0);
        check("drain_count", got.size(), 22);
        if (got.size() == 22) begin
            for (int i = 0; i < 16; i++) check("drain_order", int'(got[i]), 8'h41 + i);
            check("drain_tail", int'(got[21]), 8'hDA);
        end

        // Data in IDLE is a protocol error; clr_err clears it
        do_reset();
        out_ready = 1'b1;
        tick(7'h7F); tick(7'h41);
        check("idle_ferr", int'(frame_err), 1);
        check("idle_level", int'(fifo_level), 0);
        tick(7'h7F); tick(7'h00); tick(7'h7F);
        check("empty_frame_cnt", int'(frame_cnt), 1);
        clr_err = 1'b1;
        tick(7'h7F);
        clr_err = 1'b0;
        check("clr_ferr", int'(frame_err), 0);

        // START inside a frame terminates it with an error
        do_reset();
        out_ready = 1'b1;
        tick(7'h7F); tick(7'h00); tick(7'h41); tick(7'h42); tick(7'h00); tick(7'h43); tick(7'h7F);
        repeat (3) tick(7'h7F);
        check("restart_count", got.size(), 3);
        if (got.size() == 3) begin
            check("restart_A", int'(got[0]), 8'h41);
            check("restart_B", int'(got[1]), 8'hC2);
            check("restart_C", int'(got[2]), 8'hC3);
        end
        check("restart_ferr", int'(frame_err), 1);
        check("restart_cnt", int'(frame_cnt), 1);

        // Asynchronous reset mid-frame
        do_reset();
        out_ready = 1'b0;
        tick(7'h7F); tick(7'h00); tick(7'h41); tick(7'h42);
        check("pre_rst_level", int'(fifo_level), 1);
        #2 reset = 1'b1;
        #1;
        check("async_level", int'(fifo_level), 0);
        check("async_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        tick(7'h43); tick(7'h7F);
        check("post_rst_level", int'(fifo_level), 0);
        check("post_rst_ferr", int'(frame_err), 0);
        check("post_rst_cnt", int'(frame_cnt), 0);

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
